m_adder_arbiter: RTL and testbench

- Shares one WIDTH-bit ripple adder between two requesters using round-robin arbitration.
- Each requester raises a request with its operands and receives a grant, then a one-cycle done pulse carrying the (WIDTH+1)-bit sum.
- Sits between the operand sources and the shared adder datapath.
- Fixed operation cadence: 3 cycles per operation.

---
 rtl/m_adder_arbiter_pkg.sv | 17 +
 rtl/m_adder_arbiter_ripple_adder.sv | 35 +++
 rtl/m_adder_arbiter.sv | 165 ++++++++++++++++
 tb/tb_m_adder_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/m_adder_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_adder_arbiter_pkg
// Description : Shared state encodings for the round-robin adder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package m_adder_arbiter_pkg;

  // FSM state type and encodings. The value 2'd3 is unused and recovers to IDLE.
  typedef logic [1:0] state_t;

  localparam state_t c_IDLE = 2'd0;
  localparam state_t c_BUSY = 2'd1;
  localparam state_t c_DONE = 2'd2;

endpackage : m_adder_arbiter_pkg
`default_nettype wire

// File: rtl/m_adder_arbiter_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module      : m_ripple_adder
// Description : WIDTH-bit ripple-carry adder built from a chain of full-adder
//               cells. The carry-in of the chain is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module m_ripple_adder
  import m_adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the final carry-out.
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = 1'b0;

  // One full-adder cell per bit position.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa_cell
      assign s[i]         = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = w_carry[WIDTH];

endmodule : m_ripple_adder
`default_nettype wire

// File: rtl/m_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : m_adder_arbiter
// Description : Shares one ripple adder between two requesters with
//               round-robin arbitration. Each operation takes exactly three
//               cycles: grant, compute/done, release.
// Revision    : 1.0 - initial release
// ============================================================================
module m_adder_arbiter
  import m_adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_prio;     // requester favoured when both request
  logic             r_winner;   // requester owning the current operation
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic [WIDTH:0]   r_sum;
  logic             r_busy;

  logic             w_any_req;
  logic             w_sel;      // requester picked in IDLE (0 or 1)
  logic             w_load;
  logic             w_gnt0_d;
  logic             w_gnt1_d;
  logic             w_done0_d;
  logic             w_done1_d;
  logic [WIDTH:0]   w_sum_d;
  logic             w_prio_d;
  logic             w_winner_d;

  logic [WIDTH-1:0] w_add_s;
  logic             w_add_cout;

  // Single shared adder; the arbiter itself does no arithmetic.
  m_ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (r_op_a),
    .b    (r_op_b),
    .s    (w_add_s),
    .cout (w_add_cout)
  );

  assign w_any_req = req0 | req1;
  // With only one request the choice follows req1; on a tie prio decides.
  assign w_sel     = (req0 & req1) ? r_prio : req1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE waits for a request, then a fixed BUSY/DONE walk.
  always_comb begin
    w_state_nxt = c_IDLE;
    case (r_state)
      c_IDLE:  w_state_nxt = w_any_req ? c_BUSY : c_IDLE;
      c_BUSY:  w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and bookkeeping.
  always_comb begin
    w_load     = 1'b0;
    w_gnt0_d   = 1'b0;
    w_gnt1_d   = 1'b0;
    w_done0_d  = 1'b0;
    w_done1_d  = 1'b0;
    w_sum_d    = r_sum;
    w_prio_d   = r_prio;
    w_winner_d = r_winner;
    case (r_state)
      c_IDLE: begin
        if (w_any_req) begin
          w_load     = 1'b1;
          w_gnt0_d   = ~w_sel;
          w_gnt1_d   = w_sel;
          w_winner_d = w_sel;
        end
      end
      c_BUSY: begin
        w_gnt0_d  = r_gnt0;
        w_gnt1_d  = r_gnt1;
        w_done0_d = ~r_winner;
        w_done1_d = r_winner;
        w_sum_d   = {w_add_cout, w_add_s};
      end
      c_DONE: begin
        // Hand priority to the requester that was not just served.
        w_prio_d = ~r_winner;
      end
      default: begin
        w_prio_d = r_prio;
      end
    endcase
  end

  // Output and datapath registers; operands are captured only at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio   <= 1'b0;
      r_winner <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_sum    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_prio   <= w_prio_d;
      r_winner <= w_winner_d;
      if (w_load) begin
        r_op_a <= w_sel ? a1 : a0;
        r_op_b <= w_sel ? b1 : b0;
      end
      r_gnt0   <= w_gnt0_d;
      r_gnt1   <= w_gnt1_d;
      r_done0  <= w_done0_d;
      r_done1  <= w_done1_d;
      r_sum    <= w_sum_d;
      r_busy   <= (w_state_nxt != c_IDLE);
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign sum   = r_sum;
  assign busy  = r_busy;

endmodule : m_adder_arbiter
`default_nettype wire

// File: tb/tb_m_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_adder_arbiter
// Description : Directed self-checking bench for the round-robin adder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_adder_arbiter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH:0]   sum;
  logic             busy;

  int checks = 0;
  int errors = 0;

  m_adder_arbiter #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .sum   (sum),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check all six outputs at once: {gnt0,gnt1,done0,done1,busy} and sum.
  task automatic check_out(input string tag, input logic [4:0] flags, input logic [WIDTH:0] s);
    check({tag, ".flags"}, {27'd0, gnt0, gnt1, done0, done1, busy}, {27'd0, flags});
    check({tag, ".sum"}, {27'd0, sum}, {27'd0, s});
  endtask

  // Mutual exclusion of grants and of done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("mutex_gnt", {31'd0, gnt0 & gnt1}, 32'd0);
      check("mutex_done", {31'd0, done0 & done1}, 32'd0);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] exp_sum;
    logic [4:0] f_gnt0;
    logic [4:0] f_gnt1;
    logic [4:0] f_done0;
    logic [4:0] f_done1;
    // Flag order: gnt0, gnt1, done0, done1, busy
    f_gnt0  = 5'b10001;
    f_gnt1  = 5'b01001;
    f_done0 = 5'b10101;
    f_done1 = 5'b01011;

    rst = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick(); tick();
    check_out("reset", 5'b00000, 5'd0);
    rst = 1'b0;

    // Single request from requester 0: 9 + 7 = 16.
    req0 = 1; a0 = 4'd9; b0 = 4'd7;
    tick(); check_out("t1_grant", f_gnt0, 5'd0);
    tick(); check_out("t1_done", f_done0, 5'd16);
    req0 = 0;
    tick(); check_out("t1_idle", 5'b00000, 5'd16);

    // Reset, then simultaneous requests: 0 served first, then 1.
    rst = 1; tick(); rst = 0;
    check_out("t2_reset", 5'b00000, 5'd0);
    req0 = 1; a0 = 4'd3; b0 = 4'd4; req1 = 1; a1 = 4'd15; b1 = 4'd15;
    tick(); check_out("t2_grant0", f_gnt0, 5'd0);
    tick(); check_out("t2_done0", f_done0, 5'd7);
    req0 = 0;
    tick(); check_out("t2_idle0", 5'b00000, 5'd7);
    tick(); check_out("t2_grant1", f_gnt1, 5'd7);
    tick(); check_out("t2_done1", f_done1, 5'd30);
    req1 = 0;
    tick(); check_out("t2_idle1", 5'b00000, 5'd30);

    // Both held for four operations: strict alternation 0,1,0,1 every 3 cycles.
    req0 = 1; a0 = 4'd1; b0 = 4'd2; req1 = 1; a1 = 4'd10; b1 = 4'd11;
    for (int i = 0; i < 4; i++) begin
      exp_sum = (i % 2 == 0) ? 5'd3 : 5'd21;
      tick(); check_out("t3_grant", (i % 2 == 0) ? f_gnt0 : f_gnt1, (i == 0) ? 5'd30 : ((i % 2 == 0) ? 5'd21 : 5'd3));
      tick(); check_out("t3_done", (i % 2 == 0) ? f_done0 : f_done1, exp_sum);
      tick(); check_out("t3_idle", 5'b00000, exp_sum);
    end
    req0 = 0; req1 = 0;
    tick(); check_out("t3_quiet", 5'b00000, 5'd21);

    // Operand change after grant is ignored: 2 + 3 = 5.
    req0 = 1; a0 = 4'd2; b0 = 4'd3;
    tick(); check_out("t4_grant", f_gnt0, 5'd21);
    a0 = 4'd15; b0 = 4'd15;
    tick(); check_out("t4_done", f_done0, 5'd5);
    req0 = 0;
    tick(); check_out("t4_idle", 5'b00000, 5'd5);

    // Reset during BUSY abandons the operation; req1 alone then proceeds.
    req0 = 1; a0 = 4'd8; b0 = 4'd8;
    tick(); check_out("t5_grant", f_gnt0, 5'd5);
    rst = 1; req0 = 0;
    tick(); check_out("t5_abort", 5'b00000, 5'd0);
    rst = 0; req1 = 1; a1 = 4'd6; b1 = 4'd5;
    tick(); check_out("t5_grant1", f_gnt1, 5'd0);
    tick(); check_out("t5_done1", f_done1, 5'd11);
    req1 = 0;
    tick(); check_out("t5_idle", 5'b00000, 5'd11);

    // Exhaustive sweep of requester 1 operands.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        req1 = 1; a1 = 4'(a); b1 = 4'(b);
        exp_sum = 5'(a + b);
        tick(); check("sweep_gnt1", {31'd0, gnt1}, 32'd1);
        tick(); check("sweep_done1", {31'd0, done1}, 32'd1);
        check("sweep_sum", {27'd0, sum}, {27'd0, exp_sum});
        req1 = 0;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_m_adder_arbiter
`default_nettype wire
